// File: rtl/hit_responder.sv
// hit_responder: turns each accepted collision hit into game state.
// A hit costs one life, blinks the object for BLINK_FRAMES frames and then
// keeps it invulnerable for COOLDOWN_FRAMES frames. Running out of lives
// parks the block in GAME_OVER until restart.
// Optional feature macro: HIT_RESPONDER_COOLDOWN_EN
//   defined     -> BLINK is followed by a COOLDOWN state
//   not defined -> BLINK returns straight to ALIVE (COOLDOWN_FRAMES unused)
module hit_responder #(
  parameter int unsigned INITIAL_LIVES   = 3,
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter int unsigned BLINK_PERIOD    = 4,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       SingleHitPulse,
  input  logic       restart,
  output logic [3:0] lives,
  output logic       blankObject,
  output logic       invulnerable,
  output logic       gameOver,
  output logic       lifeLostPulse
);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    BLINK     = 2'd1,
`ifdef HIT_RESPONDER_COOLDOWN_EN
    COOLDOWN  = 2'd2,
`endif
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [3:0] LIVES_INIT = 4'(INITIAL_LIVES);
  localparam logic [7:0] BLINK_END  = 8'(BLINK_FRAMES);
  localparam logic [7:0] PERIOD_END = 8'(BLINK_PERIOD);
`ifdef HIT_RESPONDER_COOLDOWN_EN
  localparam logic [7:0] COOL_END   = 8'(COOLDOWN_FRAMES);
`else
  logic unused_cooldown_frames;
  assign unused_cooldown_frames = ^COOLDOWN_FRAMES;
`endif

  state_t     state;
  logic [7:0] frame_cnt;
  logic [7:0] phase_cnt;
  logic [7:0] frame_inc;
  logic [7:0] phase_inc;

  // Next values of the frame counter and of the blink-phase counter; the phase
  // counter wraps every BLINK_PERIOD frames so a wrap marks a multiple of the period.
  always_comb begin
    frame_inc = frame_cnt + 8'd1;
    phase_inc = phase_cnt + 8'd1;
  end

  // Single state machine with every output registered alongside the state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= ALIVE;
      lives         <= LIVES_INIT;
      frame_cnt     <= 8'd0;
      phase_cnt     <= 8'd0;
      blankObject   <= 1'b0;
      invulnerable  <= 1'b0;
      gameOver      <= 1'b0;
      lifeLostPulse <= 1'b0;
    end else begin
      lifeLostPulse <= 1'b0;
      if (restart) begin
        state        <= ALIVE;
        lives        <= LIVES_INIT;
        frame_cnt    <= 8'd0;
        phase_cnt    <= 8'd0;
        blankObject  <= 1'b0;
        invulnerable <= 1'b0;
        gameOver     <= 1'b0;
      end else begin
        case (state)
          ALIVE: begin
            if (SingleHitPulse && (lives != 4'd0)) begin
              lifeLostPulse <= 1'b1;
              lives         <= lives - 4'd1;
              frame_cnt     <= 8'd0;
              phase_cnt     <= 8'd0;
              blankObject   <= 1'b1;
              invulnerable  <= 1'b1;
              if (lives == 4'd1) begin
                state    <= GAME_OVER;
                gameOver <= 1'b1;
              end else begin
                state <= BLINK;
              end
            end
          end
          BLINK: begin
            if (startOfFrame) begin
              if (frame_inc == BLINK_END) begin
                frame_cnt   <= 8'd0;
                phase_cnt   <= 8'd0;
                blankObject <= 1'b0;
`ifdef HIT_RESPONDER_COOLDOWN_EN
                state       <= COOLDOWN;
`else
                state        <= ALIVE;
                invulnerable <= 1'b0;
`endif
              end else begin
                frame_cnt <= frame_inc;
                if (phase_inc == PERIOD_END) begin
                  phase_cnt   <= 8'd0;
                  blankObject <= ~blankObject;
                end else begin
                  phase_cnt <= phase_inc;
                end
              end
            end
          end
`ifdef HIT_RESPONDER_COOLDOWN_EN
          COOLDOWN: begin
            blankObject <= 1'b0;
            if (startOfFrame) begin
              if (frame_inc == COOL_END) begin
                state        <= ALIVE;
                frame_cnt    <= 8'd0;
                invulnerable <= 1'b0;
              end else begin
                frame_cnt <= frame_inc;
              end
            end
          end
`endif
          GAME_OVER: begin
            blankObject  <= 1'b1;
            invulnerable <= 1'b1;
            gameOver     <= 1'b1;
          end
          default: begin
            state <= ALIVE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_responder.sv
// tb_hit_responder: directed scoreboard bench for hit_responder.
// Built with INITIAL_LIVES=2, BLINK_FRAMES=4, BLINK_PERIOD=2, COOLDOWN_FRAMES=3.
// Expectations follow HIT_RESPONDER_COOLDOWN_EN as defined for this compile.
module tb_hit_responder;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       SingleHitPulse;
  logic       restart;
  logic [3:0] lives;
  logic       blankObject;
  logic       invulnerable;
  logic       gameOver;
  logic       lifeLostPulse;

  int tests    = 0;
  int failures = 0;

  // Expected output snapshot: {lives, blankObject, invulnerable, gameOver, lifeLostPulse}
  logic [7:0] exp_q[$];
  string      name_q[$];

  hit_responder #(
    .INITIAL_LIVES  (2),
    .BLINK_FRAMES   (4),
    .BLINK_PERIOD   (2),
    .COOLDOWN_FRAMES(3)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .SingleHitPulse(SingleHitPulse),
    .restart       (restart),
    .lives         (lives),
    .blankObject   (blankObject),
    .invulnerable  (invulnerable),
    .gameOver      (gameOver),
    .lifeLostPulse (lifeLostPulse)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the current DUT outputs against one expected snapshot.
  task automatic checkOutput(input string name, input logic [7:0] expv);
    logic [7:0] act;
    act = {lives, blankObject, invulnerable, gameOver, lifeLostPulse};
    tests++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got lives=%0d blank=%b invul=%b over=%b pulse=%b, expected lives=%0d blank=%b invul=%b over=%b pulse=%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               expv[7:4], expv[3], expv[2], expv[1], expv[0]);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response
  // expected right after the next rising edge.
  task automatic applyStimulus(input logic sof, input logic hit, input logic rs,
                               input logic [3:0] l, input logic b, input logic i,
                               input logic g, input logic p, input string name);
    @(negedge clk);
    startOfFrame   = sof;
    SingleHitPulse = hit;
    restart        = rs;
    exp_q.push_back({l, b, i, g, p});
    name_q.push_back(name);
  endtask

  // Monitor: after every rising edge, check the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      checkOutput(name_q.pop_front(), exp_q.pop_front());
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN         = 1'b0;
    startOfFrame   = 1'b0;
    SingleHitPulse = 1'b0;
    restart        = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("in_reset", {4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    resetN = 1'b1;
    #1;
    checkOutput("reset_release", {4'd2, 1'b0, 1'b0, 1'b0, 1'b0});

    //            sof  hit  rs   lives  b     i     g     p
    applyStimulus(1'b0,1'b0,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0,"idle");
    applyStimulus(1'b0,1'b1,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b1,"hit1");
    applyStimulus(1'b0,1'b0,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b0,"pulse_drop");
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b0,"blink_sof1");
    applyStimulus(1'b0,1'b1,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b0,"blink_hit_nosof");
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b0,1'b1,1'b0,1'b0,"blink_sof2");
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b0,1'b1,1'b0,1'b0,"blink_sof3");
`ifdef HIT_RESPONDER_COOLDOWN_EN
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b0,1'b1,1'b0,1'b0,"blink_sof4_cooldown");
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b0,1'b1,1'b0,1'b0,"cool_sof1");
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b0,1'b1,1'b0,1'b0,"cool_sof2");
    applyStimulus(1'b1,1'b0,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b0,"cool_sof3_alive");
`else
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b0,"blink_sof4_alive");
`endif
    applyStimulus(1'b0,1'b0,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b0,"alive_idle");
    applyStimulus(1'b0,1'b1,1'b0,4'd0, 1'b1,1'b1,1'b1,1'b1,"last_hit_gameover");
    applyStimulus(1'b1,1'b1,1'b0,4'd0, 1'b1,1'b1,1'b1,1'b0,"gameover_hit_ignored");
    applyStimulus(1'b0,1'b0,1'b0,4'd0, 1'b1,1'b1,1'b1,1'b0,"gameover_hold");
    applyStimulus(1'b0,1'b0,1'b1,4'd2, 1'b0,1'b0,1'b0,1'b0,"restart_from_gameover");
    applyStimulus(1'b0,1'b1,1'b1,4'd2, 1'b0,1'b0,1'b0,1'b0,"restart_beats_hit");
    applyStimulus(1'b1,1'b1,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b1,"hit_with_sof");
    applyStimulus(1'b1,1'b0,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b0,"sof_after_hit_is_first");
    applyStimulus(1'b1,1'b0,1'b0,4'd1, 1'b0,1'b1,1'b0,1'b0,"sof_after_hit_second");
    applyStimulus(1'b0,1'b0,1'b1,4'd2, 1'b0,1'b0,1'b0,1'b0,"restart_mid_blink");
    applyStimulus(1'b0,1'b1,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b1,"held_hit_first");
    applyStimulus(1'b0,1'b1,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b0,"held_hit_second");
    applyStimulus(1'b1,1'b0,1'b0,4'd1, 1'b1,1'b1,1'b0,1'b0,"pre_async_sof");

    // Asynchronous reset in the middle of BLINK, checked before any clock edge.
    @(negedge clk);
    startOfFrame   = 1'b0;
    SingleHitPulse = 1'b0;
    restart        = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("async_reset_mid_blink", {4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(1'b1,1'b0,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0,"after_async_reset");
    applyStimulus(1'b0,1'b0,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0,"final_idle");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
